mc_ctrl_fsm: RTL
================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the 16-bit MIPS datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the load enables of the 16-bit state registers (PC, IR, MDR, A/B, ALUOut), the register-file write, memory strobes and datapath mux selects.
- Waits on a memory-ready handshake, with a bounded timeout.

Parameters:
- OPW, 4, opcode width (instr[15:12]).
- MEM_TIMEOUT, 15, max cycles to wait for mem_ready before aborting to FETCH.
- TW, 4, width of the wait counter; must satisfy 2^TW > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- Clear  in  1  synchronous active-high reset.
- opcode  in  OPW  IR[15:12]; sampled in DECODE.
- zero  in  1  ALU zero flag, used in BRANCH.
- mem_ready  in  1  memory completes the current rd/wr this cycle.
- pc_we  out  1  load PC register.
- ir_we  out  1  load IR.
- mdr_we  out  1  load MDR.
- ab_we  out  1  load A/B operand registers.
- alu_we  out  1  load ALUOut.
- rf_we  out  1  register-file write.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- iord  out  1  memory address: 0 = PC, 1 = ALUOut.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  0 = B, 1 = const 2, 2 = sign-ext imm, 3 = imm<<1.
- alu_op  out  2  0 = add, 1 = sub, 2 = funct-decoded.
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- illegal  out  1  sticky; set on an undefined opcode.
- bus_err  out  1  sticky; set on a memory timeout.
- state  out  4  current state, for debug.

Behaviour:
- Clear=1 at an edge: state<=FETCH, wait counter<=0, illegal<=0, bus_err<=0.
- While Clear=1, every write enable and mem_rd/mem_wr is forced to 0.
- Outputs are Moore-decoded from state, except that pc_we, ir_we and mdr_we are additionally gated by mem_ready/zero as listed below.
- Opcodes: 0 R-type, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 J; all others illegal.

State behaviour:
- FETCH: mem_rd=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=add, pc_src=0.
  - If mem_ready: ir_we=1, pc_we=1 (PC+=2), go to DECODE.
  - Else hold FETCH.
- DECODE: ab_we=1; alu computes PC+(imm<<1) into ALUOut (alu_we=1, src_a=0, src_b=3). Next state by opcode:
  - 0 -> EXEC_R
  - 1 -> EXEC_I
  - 2, 3 -> MEM_ADDR
  - 4 -> BRANCH
  - 5 -> JUMP
  - other -> FETCH with illegal<=1; no other side effects.
- EXEC_R: src_a=1, src_b=0, alu_op=2, alu_we=1 -> R_WB.
- R_WB: rf_we=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- EXEC_I: src_a=1, src_b=2, alu_op=add, alu_we=1 -> I_WB.
- I_WB: rf_we=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- MEM_ADDR: src_a=1, src_b=2, alu_op=add, alu_we=1 -> MEM_RD if LW, MEM_WR if SW.
- MEM_RD: mem_rd=1, iord=1; mdr_we=mem_ready; on mem_ready -> LD_WB.
- LD_WB: rf_we=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEM_WR: mem_wr=1, iord=1; on mem_ready -> FETCH.
- BRANCH: src_a=1, src_b=0, alu_op=sub, pc_src=1, pc_we=zero -> FETCH.
- JUMP: pc_src=2, pc_we=1 -> FETCH.

Latency with mem_ready tied to 1:
- R-type, ADDI, SW: 4 cycles.
- LW: 5 cycles.
- BEQ, J: 3 cycles.

Memory wait and timeout:
- The wait counter increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
- It clears on mem_ready=1 or on leaving the state.
- If the counter reaches MEM_TIMEOUT while mem_ready=0: bus_err<=1, go to FETCH, and all enables stay 0 that cycle.
- A timeout in FETCH re-fetches the same PC.

Boundary cases:
- mem_ready=1 on the same cycle the counter hits MEM_TIMEOUT: the completion wins; no error is flagged.
- Clear asserted mid-instruction: next cycle is FETCH; a partial instruction leaves no rf/PC write.
- illegal and bus_err are cleared only by Clear.

Decomposition:
- Package mc_ctrl_pkg: state encoding (4-bit localparams FETCH=0 … JUMP=11), opcode constants, alu_op/alu_src_b/pc_src codes. Shared with the datapath and the bench.
- Sub-module mem_wait_timer: counter with inc/clear/expired, parameterised by MEM_TIMEOUT and TW.

Test Plan:
- Clear=1 for 2 cycles, then release with mem_ready=1 -> state=FETCH, all enables 0 during Clear; ir_we=pc_we=1 on the first cycle after release.
- R-type (opcode 0), mem_ready=1 -> states FETCH, DECODE, EXEC_R, R_WB, FETCH; rf_we=1 with reg_dst=1 only in cycle 4.
- LW with mem_ready delayed 3 cycles in MEM_RD -> mem_rd held 4 cycles; mdr_we pulses once; rf_we with mem_to_reg=1 the next cycle; total 8 cycles.
- BEQ with zero=1, then zero=0 -> pc_we=1 with pc_src=1 in cycle 3 for the first; pc_we=0 for the second.
- Opcode 9 -> DECODE returns to FETCH; illegal=1 and stays 1 until Clear; rf_we/mem_wr never asserted.
- mem_ready held 0 in MEM_WR -> after 15 wait cycles bus_err=1, state=FETCH, mem_wr deasserted; repeat with mem_ready=1 exactly at cycle 15 -> no bus_err.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_pkg
//  Purpose  : Shared encodings for the multi-cycle MIPS-16 control sequencer:
//             state codes, opcodes and datapath select codes.
//  Revision : 1.0
// ============================================================================
package mc_ctrl_pkg;

  // Sequencer states; the numeric values appear on the debug state port.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    R_WB     = 4'd3,
    EXEC_I   = 4'd4,
    I_WB     = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    LD_WB    = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11
  } state_e;

  // Opcodes (instr[15:12])
  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_LW    = 4'd2;
  localparam logic [3:0] OP_SW    = 4'd3;
  localparam logic [3:0] OP_BEQ   = 4'd4;
  localparam logic [3:0] OP_J     = 4'd5;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_TWO    = 2'd1;
  localparam logic [1:0] SRCB_SIMM   = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // States that wait on the memory-ready handshake.
  function automatic logic is_mem_wait(state_e s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_fsm_if
//  Purpose  : Control bundle between the sequencer (slave) and the datapath /
//             memory side (master).
//  Revision : 1.0
// ============================================================================
interface mc_ctrl_fsm_if #(
  parameter int OPW = 4
);
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           mem_ready;
  logic           pc_we;
  logic           ir_we;
  logic           mdr_we;
  logic           ab_we;
  logic           alu_we;
  logic           rf_we;
  logic           mem_rd;
  logic           mem_wr;
  logic           iord;
  logic           alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     alu_op;
  logic [1:0]     pc_src;
  logic           reg_dst;
  logic           mem_to_reg;
  logic           illegal;
  logic           bus_err;
  logic [3:0]     state;

  // Datapath side: supplies status, consumes controls.
  modport master (
    output opcode, zero, mem_ready,
    input  pc_we, ir_we, mdr_we, ab_we, alu_we, rf_we, mem_rd, mem_wr, iord,
           alu_src_a, alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg,
           illegal, bus_err, state
  );

  // Sequencer side.
  modport slave (
    input  opcode, zero, mem_ready,
    output pc_we, ir_we, mdr_we, ab_we, alu_we, rf_we, mem_rd, mem_wr, iord,
           alu_src_a, alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg,
           illegal, bus_err, state
  );
endinterface
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wait_timer
//  Purpose  : Counts cycles spent waiting on memory; flags when the count has
//             reached MEM_TIMEOUT.
//  Revision : 1.0
// ============================================================================
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic inc_i,
  input  wire logic clr_i,
  output logic      expired_o
);

  logic [TW-1:0] cnt_q;

  // Wait counter: clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == TW'(MEM_TIMEOUT));

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_fsm
//  Purpose  : Multi-cycle control sequencer for the 16-bit MIPS datapath.
//             FETCH/DECODE/EXEC/MEM/WB with memory-ready wait and timeout.
//  Revision : 1.0
// ============================================================================
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPW         = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 4
) (
  input  wire logic     clk,
  input  wire logic     Clear,
  mc_ctrl_fsm_if.slave  bus
);

  state_e state_q;
  logic   is_lw_q;
  logic   illegal_q;
  logic   bus_err_q;

  logic   w_in_wait;
  logic   w_expired;
  logic   w_abort;

  // A timeout only counts when memory is still not ready; completion wins.
  assign w_in_wait = is_mem_wait(state_q);
  assign w_abort   = w_in_wait && !bus.mem_ready && w_expired;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TW          (TW)
  ) u_timer (
    .clk       (clk),
    .rst       (Clear),
    .inc_i     (w_in_wait && !bus.mem_ready),
    .clr_i     (!w_in_wait || bus.mem_ready),
    .expired_o (w_expired)
  );

  // State sequencing plus sticky error flags and the latched LW/SW choice.
  always_ff @(posedge clk) begin
    if (Clear) begin
      state_q   <= FETCH;
      is_lw_q   <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else if (w_abort) begin
      state_q   <= FETCH;
      bus_err_q <= 1'b1;
    end else begin
      case (state_q)
        FETCH:    if (bus.mem_ready) state_q <= DECODE;
        DECODE: begin
          is_lw_q <= (bus.opcode == OPW'(OP_LW));
          case (bus.opcode)
            OPW'(OP_RTYPE): state_q <= EXEC_R;
            OPW'(OP_ADDI):  state_q <= EXEC_I;
            OPW'(OP_LW),
            OPW'(OP_SW):    state_q <= MEM_ADDR;
            OPW'(OP_BEQ):   state_q <= BRANCH;
            OPW'(OP_J):     state_q <= JUMP;
            default: begin
              state_q   <= FETCH;
              illegal_q <= 1'b1;
            end
          endcase
        end
        EXEC_R:   state_q <= R_WB;
        EXEC_I:   state_q <= I_WB;
        MEM_ADDR: state_q <= is_lw_q ? MEM_RD : MEM_WR;
        MEM_RD:   if (bus.mem_ready) state_q <= LD_WB;
        MEM_WR:   if (bus.mem_ready) state_q <= FETCH;
        default:  state_q <= FETCH;
      endcase
    end
  end

  // Moore control decode; PC/IR/MDR loads qualified by mem_ready or zero.
  always_comb begin
    bus.pc_we      = 1'b0;
    bus.ir_we      = 1'b0;
    bus.mdr_we     = 1'b0;
    bus.ab_we      = 1'b0;
    bus.alu_we     = 1'b0;
    bus.rf_we      = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.iord       = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_B;
    bus.alu_op     = ALU_ADD;
    bus.pc_src     = PCSRC_ALU;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    case (state_q)
      FETCH: begin
        bus.mem_rd    = 1'b1;
        bus.alu_src_b = SRCB_TWO;
        bus.pc_we     = bus.mem_ready;
        bus.ir_we     = bus.mem_ready;
      end
      DECODE: begin
        bus.ab_we     = 1'b1;
        bus.alu_we    = 1'b1;
        bus.alu_src_b = SRCB_IMM_SH;
      end
      EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_FUNCT;
        bus.alu_we    = 1'b1;
      end
      R_WB: begin
        bus.rf_we     = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      EXEC_I, MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_SIMM;
        bus.alu_we    = 1'b1;
      end
      I_WB:     bus.rf_we = 1'b1;
      MEM_RD: begin
        bus.mem_rd    = 1'b1;
        bus.iord      = 1'b1;
        bus.mdr_we    = bus.mem_ready;
      end
      LD_WB: begin
        bus.rf_we      = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        bus.mem_wr    = 1'b1;
        bus.iord      = 1'b1;
      end
      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_SUB;
        bus.pc_src    = PCSRC_ALUOUT;
        bus.pc_we     = bus.zero;
      end
      JUMP: begin
        bus.pc_src    = PCSRC_JUMP;
        bus.pc_we     = 1'b1;
      end
      default: ;
    endcase
    if (Clear) begin
      bus.pc_we  = 1'b0;
      bus.ir_we  = 1'b0;
      bus.mdr_we = 1'b0;
      bus.ab_we  = 1'b0;
      bus.alu_we = 1'b0;
      bus.rf_we  = 1'b0;
      bus.mem_rd = 1'b0;
      bus.mem_wr = 1'b0;
    end
  end

  assign bus.illegal = illegal_q;
  assign bus.bus_err = bus_err_q;
  assign bus.state   = state_q;

endmodule
`default_nettype wire
